set_assoc_icache: RTL and testbench
===================================

Name: set_assoc_icache

Overview:
- Parametrised N-way set-associative, read-only instruction cache between the fetch stage and a pipelined Wishbone-style bus.
- Successor of the 2-way, 256-set, 8-word-line fetch cache. Adds configurable ways, sets and line size.
- Adds a latched miss address, a pipelined burst fill honouring BusStall and BusAcknowledge, round-robin replacement with invalid-first fill, and a single-cycle Flush.

Parameters:
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 256, sets per way; power of 2, ≥2.
- LINE_WORDS, 8, 32-bit words per line; power of 2, ≥2.
- ADDR_WIDTH, 32, byte address width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- InstructionAddress  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- FetchRequest  in  1  request valid; sampled only in IDLE.
- Instruction  out  32  fetched word; valid while InstructionReady=1.
- InstructionReady  out  1  one-cycle response pulse.
- Flush  in  1  invalidate every line.
- BusCycle  out  1  bus cycle active.
- BusStrobe  out  1  request strobe.
- BusReadWrite  out  1  tied 0 (read).
- BusAcknowledge  in  1  read data valid on MemoryDataIn.
- BusStall  in  1  slave cannot accept the request this cycle.
- MemoryAddress  out  ADDR_WIDTH  bus word address.
- MemoryDataIn  in  32  bus read data.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS), IDX = log2(SETS), TAG = ADDR_WIDTH-IDX-OFF-2.
  - Fields: addr = {tag, index, offset, 2'b00}.
- Storage per way: Tag[SETS], Valid[SETS], Data[SETS][LINE_WORDS]. Per set: Victim pointer, log2(WAYS) bits; zero-width when WAYS=1.
- Reset (asynchronous, any state including mid-fill):
  - All Valid=0, Victim=0, state IDLE.
  - BusCycle=BusStrobe=0, MemoryAddress=0, Instruction=0, InstructionReady=0.
  - Outstanding acks after reset are ignored.
- States: IDLE, FILL.
- IDLE, FetchRequest=1:
  - Compare the tag against all ways of the indexed set.
  - Hit: next cycle Instruction=Data[way][index][offset], InstructionReady=1. Hit latency 1 cycle; throughput 1 hit per cycle.
  - More than one way matching is impossible by construction; no priority is required.
  - Miss: latch tag/index/offset into MissReg. Choose the fill way: lowest-index invalid way, else Victim[index].
  - Miss, next cycle: BusCycle=1, BusStrobe=1, MemoryAddress={tag,index,0,2'b00}, IssueCount=0, AckCount=0, state FILL, InstructionReady=0.
- FILL:
  - Uses MissReg only; changes to InstructionAddress are ignored.
  - Issue: when BusStrobe=1 and BusStall=0, IssueCount+1 and MemoryAddress word field=IssueCount+1. After LINE_WORDS accepted issues, BusStrobe=0.
  - Ack: when BusAcknowledge=1, write Data[fillway][index][AckCount]=MemoryDataIn and AckCount+1. An ack may coincide with an issue; both are counted that cycle.
  - Last ack (AckCount=LINE_WORDS-1):
    - Set Valid, write Tag, advance Victim[index]=fillway+1 mod WAYS (only when no invalid way existed).
    - Next cycle: BusCycle=0, Instruction=requested word (bypassed from MemoryDataIn if the offset is the last word), InstructionReady=1, state IDLE.
  - The IDLE cycle carrying InstructionReady may accept a new FetchRequest.
  - FetchRequest during FILL is ignored; the requester holds it.
- Miss penalty, zero stall/zero-wait slave: LINE_WORDS+2 cycles from request sample to InstructionReady.
- Flush:
  - In IDLE: clears all Valid and Victim in 1 cycle. Flush takes priority over a same-cycle FetchRequest, which is dropped (no response).
  - In FILL: recorded as pending. Applied in the cycle the fill completes, after the response is produced, so the filled line is also invalidated.
- Counters are OFF+1 bits, with no wrap inside a fill. MemoryAddress word field wraps only at the line end, never into the next index.

Test Plan:
- Cold miss, WAYS=2: fetch 0x0000_1004, zero-stall slave returning word i=0xA000_0000+i → 8 bus addresses 0x1000..0x101C; Instruction=0xA000_0001 with Ready 10 cycles after request; refetch 0x1008 hits next cycle → 0xA000_0002.
- BusStall=1 for 3 cycles after the first issue, acks delayed 2 cycles → MemoryAddress holds during stall; no word lost; all 8 words correct; Ready only after the 8th ack.
- Three tags mapping to index 5 (0x0000_00A0, 0x0000_20A0, 0x0000_40A0), WAYS=2 → third fill evicts way 0 (victim); 0x20A0 still hits; 0x00A0 misses.
- Back-to-back hits at 0x1000, 0x1004, 0x1008 on consecutive cycles → three consecutive Ready pulses, in order.
- Flush asserted mid-fill → response delivered; next fetch to the same address misses (new bus cycle).
- Reset asserted mid-fill at ack 4 → BusCycle/BusStrobe drop asynchronously; Ready=0; subsequent fetch misses; stray acks ignored.

Source files
------------

// File: rtl/set_assoc_icache.sv
// N-way set-associative read-only instruction cache with a pipelined burst line fill
// over a Wishbone-style bus, round-robin replacement and a single-cycle flush.
module set_assoc_icache #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 256,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] InstructionAddress,
  input  logic                  FetchRequest,
  output logic [31:0]           Instruction,
  output logic                  InstructionReady,
  input  logic                  Flush,
  output logic                  BusCycle,
  output logic                  BusStrobe,
  output logic                  BusReadWrite,
  input  logic                  BusAcknowledge,
  input  logic                  BusStall,
  output logic [ADDR_WIDTH-1:0] MemoryAddress,
  input  logic [31:0]           MemoryDataIn
);

  localparam int unsigned OFF = $clog2(LINE_WORDS);
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = ADDR_WIDTH - IDX - OFF - 2;
  localparam int unsigned WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CW  = OFF + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;

  logic [TAG-1:0]            tag_mem  [WAYS][SETS];
  logic [31:0]               data_mem [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [SETS-1:0][WB-1:0]   victim_q;

  logic [TAG-1:0] req_tag, miss_tag;
  logic [IDX-1:0] req_idx, miss_idx;
  logic [OFF-1:0] req_off, miss_off;
  logic [WB-1:0]  hit_way, inv_way, fill_way, victim_adv;
  logic           hit, any_inv, use_victim, flush_pend;
  logic [CW-1:0]  issue_cnt, ack_cnt, issue_inc;
  logic [31:0]    rd_word, fill_word;
  logic           issue_ok, last_ack, unused_addr_bits;

  assign req_tag          = InstructionAddress[ADDR_WIDTH-1 -: TAG];
  assign req_idx          = InstructionAddress[OFF+2 +: IDX];
  assign req_off          = InstructionAddress[2 +: OFF];
  assign unused_addr_bits = ^InstructionAddress[1:0];
  assign BusReadWrite     = 1'b0;

  assign rd_word    = data_mem[hit_way][req_idx][req_off];
  assign fill_word  = data_mem[fill_way][miss_idx][miss_off];
  assign issue_ok   = (state == FILL) && BusStrobe && !BusStall;
  assign last_ack   = (state == FILL) && BusAcknowledge && (ack_cnt == LAST);
  assign issue_inc  = issue_cnt + 1'b1;
  assign victim_adv = (WAYS == 1) ? '0 : fill_way + 1'b1;

  // Tags are unique within a set, so the hit way needs no priority encoding.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[WB'(w)][req_idx] && (tag_mem[WB'(w)][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[WB'(w)][req_idx] && !any_inv) begin
        any_inv = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (FetchRequest && !Flush && !hit) state_nxt = FILL;
      FILL:    if (last_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q          <= '0;
      victim_q         <= '0;
      flush_pend       <= 1'b0;
      Instruction      <= '0;
      InstructionReady <= 1'b0;
      BusCycle         <= 1'b0;
      BusStrobe        <= 1'b0;
      MemoryAddress    <= '0;
      miss_tag         <= '0;
      miss_idx         <= '0;
      miss_off         <= '0;
      fill_way         <= '0;
      use_victim       <= 1'b0;
      issue_cnt        <= '0;
      ack_cnt          <= '0;
    end else begin
      InstructionReady <= 1'b0;
      if (state == IDLE) begin
        if (Flush) begin
          valid_q  <= '0;
          victim_q <= '0;
        end else if (FetchRequest) begin
          if (hit) begin
            Instruction      <= rd_word;
            InstructionReady <= 1'b1;
          end else begin
            miss_tag      <= req_tag;
            miss_idx      <= req_idx;
            miss_off      <= req_off;
            fill_way      <= any_inv ? inv_way : victim_q[req_idx];
            use_victim    <= !any_inv;
            BusCycle      <= 1'b1;
            BusStrobe     <= 1'b1;
            MemoryAddress <= {req_tag, req_idx, {OFF{1'b0}}, 2'b00};
            issue_cnt     <= '0;
            ack_cnt       <= '0;
            flush_pend    <= 1'b0;
          end
        end
      end else begin
        if (Flush) flush_pend <= 1'b1;
        if (issue_ok) begin
          issue_cnt                <= issue_inc;
          MemoryAddress[2 +: OFF]  <= issue_inc[OFF-1:0];
          if (issue_cnt == LAST) BusStrobe <= 1'b0;
        end
        if (BusAcknowledge) begin
          ack_cnt <= ack_cnt + 1'b1;
          if (ack_cnt == LAST) begin
            // The last word is not in the array yet, so it is taken from the bus directly.
            Instruction      <= (miss_off == LAST[OFF-1:0]) ? MemoryDataIn : fill_word;
            InstructionReady <= 1'b1;
            BusCycle         <= 1'b0;
            BusStrobe        <= 1'b0;
            flush_pend       <= 1'b0;
            if (flush_pend || Flush) begin
              valid_q  <= '0;
              victim_q <= '0;
            end else begin
              valid_q[fill_way][miss_idx] <= 1'b1;
              if (use_victim) victim_q[miss_idx] <= victim_adv;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if ((state == FILL) && BusAcknowledge)
      data_mem[fill_way][miss_idx][ack_cnt[OFF-1:0]] <= MemoryDataIn;
    if (last_ack)
      tag_mem[fill_way][miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Directed bench for set_assoc_icache: a bus slave model with programmable stall and
// ack delay serves line fills; hit/miss latency and fetched data are checked.
module tb_set_assoc_icache;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] InstructionAddress;
  logic        FetchRequest;
  logic [31:0] Instruction;
  logic        InstructionReady;
  logic        Flush;
  logic        BusCycle, BusStrobe, BusReadWrite;
  logic        BusAcknowledge, BusStall;
  logic [31:0] MemoryAddress;
  logic [31:0] MemoryDataIn;

  set_assoc_icache #(.WAYS(2), .SETS(256), .LINE_WORDS(8), .ADDR_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstructionAddress(InstructionAddress), .FetchRequest(FetchRequest),
    .Instruction(Instruction), .InstructionReady(InstructionReady), .Flush(Flush),
    .BusCycle(BusCycle), .BusStrobe(BusStrobe), .BusReadWrite(BusReadWrite),
    .BusAcknowledge(BusAcknowledge), .BusStall(BusStall),
    .MemoryAddress(MemoryAddress), .MemoryDataIn(MemoryDataIn)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave: word data = data_base + word index; ack 1+ack_extra cycles after acceptance;
  // after the first accepted issue of a fill, stall for stall_cfg cycles.
  logic [31:0] data_base  = '0;
  int          stall_cfg  = 0;
  int          ack_extra  = 0;
  int          stall_left = 0;
  bit          first_seen = 0;
  int          cyc        = 0;
  int          acks_sent  = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc_log[$];

  initial begin
    BusStall       = 1'b0;
    BusAcknowledge = 1'b0;
    MemoryDataIn   = '0;
    forever begin
      @(negedge Clock);
      cyc++;
      BusAcknowledge = 1'b0;
      MemoryDataIn   = '0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        BusAcknowledge = 1'b1;
        MemoryDataIn   = data_base + {29'd0, q_addr[0][4:2]};
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
        acks_sent++;
      end
      if (stall_left > 0) begin
        BusStall = 1'b1;
        stall_left--;
      end else begin
        BusStall = 1'b0;
      end
      if (BusCycle && BusStrobe && !BusStall && !Reset) begin
        acc_log.push_back(MemoryAddress);
        q_addr.push_back(MemoryAddress);
        q_due.push_back(cyc + 1 + ack_extra);
        if (!first_seen) begin
          first_seen = 1;
          stall_left = stall_cfg;
        end
      end
    end
  end

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] base,
                       input int exp_lat, input logic [31:0] exp_data);
    int          lat;
    logic [31:0] got;
    lat = 0;
    got = '0;
    @(negedge Clock);
    data_base = base;
    acc_log.delete();
    first_seen = 0;
    InstructionAddress = addr;
    FetchRequest = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clock);
      #1;
      FetchRequest = 1'b0;
      if (InstructionReady) begin
        lat = n;
        got = Instruction;
        break;
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_data"}, got, exp_data);
  endtask

  task automatic check_log(input string tag, input logic [31:0] base);
    check_eq({tag, "_count"}, acc_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < acc_log.size()) check_eq($sformatf("%s_%0d", tag, i), acc_log[i], base + 32'(4 * i));
  endtask

  initial begin
    int a0;
    bit ok;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
    a0 = 0; ok = 0;
  end

  initial begin
    int a0;
    bit ok;
    Reset = 1'b0;
    FetchRequest = 1'b0;
    Flush = 1'b0;
    InstructionAddress = '0;
    #1 Reset = 1'b1;
    #11;
    check_eq("rst_cyc", BusCycle, 0);
    check_eq("rst_stb", BusStrobe, 0);
    check_eq("rst_addr", MemoryAddress, 0);
    check_eq("rst_instr", Instruction, 0);
    check_eq("rst_rdy", InstructionReady, 0);
    check_eq("rst_rw", BusReadWrite, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Cold miss then hit in the freshly filled line
    fetch("cold", 32'h0000_1004, 32'hA000_0000, 10, 32'hA000_0001);
    check_log("cold_bus", 32'h0000_1000);
    fetch("rehit", 32'h0000_1008, 32'h0, 1, 32'hA000_0002);

    // Stalled, slow slave; requested word is the last of the line
    stall_cfg = 3;
    ack_extra = 2;
    a0 = acks_sent;
    fetch("stall", 32'h0000_301C, 32'hB000_0000, 15, 32'hB000_0007);
    check_eq("stall_acks", acks_sent - a0, 8);
    check_log("stall_bus", 32'h0000_3000);
    stall_cfg = 0;
    ack_extra = 0;
    fetch("stall_hit", 32'h0000_3000, 32'h0, 1, 32'hB000_0000);
    fetch("way0_hit", 32'h0000_1000, 32'h0, 1, 32'hA000_0000);

    // Three tags on index 5: third fill evicts way 0
    fetch("idx5_a", 32'h0000_00A0, 32'hC000_0000, 10, 32'hC000_0000);
    fetch("idx5_b", 32'h0000_20A0, 32'hD000_0000, 10, 32'hD000_0000);
    fetch("idx5_c", 32'h0000_40A0, 32'hE000_0000, 10, 32'hE000_0000);
    fetch("idx5_b_hit", 32'h0000_20A0, 32'h0, 1, 32'hD000_0000);
    fetch("idx5_a_miss", 32'h0000_00A0, 32'hC000_0000, 10, 32'hC000_0000);
    fetch("idx5_c_hit", 32'h0000_40A0, 32'h0, 1, 32'hE000_0000);

    // Back-to-back hits
    @(negedge Clock);
    InstructionAddress = 32'h0000_1000;
    FetchRequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check_eq($sformatf("b2b%0d_rdy", i), InstructionReady, 1);
      check_eq($sformatf("b2b%0d_data", i), Instruction, 32'hA000_0000 + 32'(i));
      InstructionAddress = 32'h0000_1004 + 32'(4 * i);
      if (i == 2) FetchRequest = 1'b0;
    end
    @(negedge Clock);
    check_eq("b2b_idle_rdy", InstructionReady, 0);

    // Flush during a fill: response still delivered, line invalidated
    fork
      fetch("flushfill", 32'h0000_5000, 32'hF000_0000, 10, 32'hF000_0000);
      begin
        repeat (4) @(negedge Clock);
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
      end
    join
    fetch("flush_refill", 32'h0000_5000, 32'hF100_0000, 10, 32'hF100_0000);
    fetch("refill_hit", 32'h0000_5000, 32'h0, 1, 32'hF100_0000);
    fetch("flushed_1000", 32'h0000_1000, 32'hA000_0000, 10, 32'hA000_0000);

    // Flush in IDLE wins over a same-cycle request
    @(negedge Clock);
    InstructionAddress = 32'h0000_5000;
    FetchRequest = 1'b1;
    Flush = 1'b1;
    @(posedge Clock);
    #1;
    FetchRequest = 1'b0;
    Flush = 1'b0;
    check_eq("flush_drop_rdy", InstructionReady, 0);
    check_eq("flush_drop_cyc", BusCycle, 0);
    fetch("post_flush", 32'h0000_5000, 32'hF200_0000, 10, 32'hF200_0000);

    // Asynchronous reset in the middle of a fill
    @(negedge Clock);
    data_base = 32'h6600_0000;
    acc_log.delete();
    first_seen = 0;
    a0 = acks_sent;
    InstructionAddress = 32'h0000_6000;
    FetchRequest = 1'b1;
    @(posedge Clock);
    #1;
    FetchRequest = 1'b0;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      #2;
      if (acks_sent - a0 == 5) begin
        ok = 1;
        break;
      end
    end
    check_eq("rst_reach_ack4", ok, 1);
    check_eq("rst_pre_stb", BusStrobe, 1);
    Reset = 1'b1;
    #1;
    check_eq("midrst_cyc", BusCycle, 0);
    check_eq("midrst_stb", BusStrobe, 0);
    check_eq("midrst_rdy", InstructionReady, 0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    check_eq("stray_cyc", BusCycle, 0);
    check_eq("stray_rdy", InstructionReady, 0);
    fetch("rst_5000", 32'h0000_5000, 32'h5500_0000, 10, 32'h5500_0000);
    fetch("rst_6004", 32'h0000_6004, 32'h1234_0000, 10, 32'h1234_0001);
    check_log("rst_bus", 32'h0000_6000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
